// File: rtl/zf_s2h_pkt_gate.sv
// zf_s2h_pkt_gate: store-and-forward gate for 64-bit AXI-stream packets.
// A packet becomes visible to the reader only after its tlast beat is stored.
// This lets the downstream datamover drain each packet back-to-back.
// A packet that cannot fit in the buffer is discarded whole and counted.
//
// state  | meaning
// ACCEPT | storing beats of the open packet; backpressure when the ring is full
// DROP   | open packet was oversize; swallow beats until its tlast
//
// rd_ptr marks the oldest word still held by the block, including words that
// were prefetched into the output pipeline. fetch_ptr is the next RAM address
// to be read. Because of this, full and occupied both count words that wait in
// the output stage.
module zf_s2h_pkt_gate #(
  parameter int SIZE      = 10,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 clear,
  input  logic [63:0]          i_tdata,
  input  logic                 i_tlast,
  input  logic                 i_tvalid,
  output logic                 i_tready,
  output logic [63:0]          o_tdata,
  output logic                 o_tlast,
  output logic                 o_tvalid,
  input  logic                 o_tready,
  output logic [CNT_WIDTH-1:0] pkt_count,
  output logic [CNT_WIDTH-1:0] drop_count,
  output logic [SIZE:0]        occupied
);

  localparam int DEPTH = 2 ** SIZE;

  typedef enum logic {ST_ACCEPT, ST_DROP} state_t;

  state_t          state;
  logic [SIZE-1:0] wr_ptr;
  logic [SIZE-1:0] commit_ptr;
  logic [SIZE-1:0] rd_ptr;
  logic [SIZE-1:0] fetch_ptr;
  logic [SIZE-1:0] wr_nxt;

  logic [64:0]     mem [DEPTH];
  logic [64:0]     ram_q;
  logic            rd_vld;
  logic [64:0]     skid_q;
  logic            skid_vld;

  logic            flush;
  logic            full;
  logic            avail;
  logic            wr_en;
  logic            oversize;
  logic            drop_last;
  logic            pop;
  logic            out_free;
  logic            take_rd;
  logic            issue;

  assign flush     = rst || clear;
  assign wr_nxt    = wr_ptr + SIZE'(1);
  assign full      = (wr_nxt == rd_ptr);
  assign avail     = (fetch_ptr != commit_ptr);

  assign i_tready  = !flush && ((state == ST_DROP) || !full);
  assign wr_en     = !flush && (state == ST_ACCEPT) && i_tvalid && !full;
  // The open packet already occupies the whole ring, so no reader can make room for it.
  assign oversize  = (state == ST_ACCEPT) && full && (commit_ptr == rd_ptr);
  assign drop_last = !flush && (state == ST_DROP) && i_tvalid && i_tlast;

  // The output pipeline has three slots: the RAM read register, the skid register and the output register.
  assign pop       = o_tvalid && o_tready;
  assign out_free  = !o_tvalid || o_tready;
  assign take_rd   = rd_vld && (out_free || !skid_vld);
  assign issue     = avail && (!rd_vld || take_rd);

  assign occupied  = {1'b0, wr_ptr - rd_ptr};

  // Packet RAM: a write port for the input side and a registered read port for prefetch.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= {i_tlast, i_tdata};
    if (issue)
      ram_q <= mem[fetch_ptr];
  end

  // Accept/drop FSM, ring pointers and the registered output stage with skid.
  always_ff @(posedge clk) begin
    if (flush) begin
      state      <= ST_ACCEPT;
      wr_ptr     <= '0;
      commit_ptr <= '0;
      rd_ptr     <= '0;
      fetch_ptr  <= '0;
      rd_vld     <= 1'b0;
      skid_vld   <= 1'b0;
      skid_q     <= '0;
      o_tvalid   <= 1'b0;
      o_tlast    <= 1'b0;
      o_tdata    <= '0;
    end else begin
      case (state)
        ST_ACCEPT: begin
          if (wr_en) begin
            wr_ptr <= wr_nxt;
            if (i_tlast)
              commit_ptr <= wr_nxt;
          end
          if (oversize) begin
            wr_ptr <= commit_ptr;
            state  <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (drop_last)
            state <= ST_ACCEPT;
        end
        default: state <= ST_ACCEPT;
      endcase

      if (issue)
        fetch_ptr <= fetch_ptr + SIZE'(1);
      if (pop)
        rd_ptr <= rd_ptr + SIZE'(1);

      if (issue)
        rd_vld <= 1'b1;
      else if (take_rd)
        rd_vld <= 1'b0;

      if (out_free) begin
        if (skid_vld) begin
          {o_tlast, o_tdata} <= skid_q;
          o_tvalid           <= 1'b1;
          skid_vld           <= rd_vld;
          skid_q             <= ram_q;
        end else if (rd_vld) begin
          {o_tlast, o_tdata} <= ram_q;
          o_tvalid           <= 1'b1;
        end else begin
          o_tvalid <= 1'b0;
        end
      end else if (!skid_vld && rd_vld) begin
        skid_q   <= ram_q;
        skid_vld <= 1'b1;
      end
    end
  end

  // Statistics: clear flushes data but keeps the counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      pkt_count  <= '0;
      drop_count <= '0;
    end else if (!clear) begin
      if (wr_en && i_tlast)
        pkt_count <= pkt_count + CNT_WIDTH'(1);
      if (drop_last && (drop_count != {CNT_WIDTH{1'b1}}))
        drop_count <= drop_count + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_zf_s2h_pkt_gate.sv
// Bench for zf_s2h_pkt_gate (SIZE=4): directed packets with a scoreboard queue
// checked by an independent output monitor.
module tb_zf_s2h_pkt_gate;
  localparam int SIZE = 4;
  localparam int CW   = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clear = 1'b0;
  logic [63:0]   i_tdata = '0;
  logic          i_tlast = 1'b0;
  logic          i_tvalid = 1'b0;
  logic          i_tready;
  logic [63:0]   o_tdata;
  logic          o_tlast;
  logic          o_tvalid;
  logic          o_tready = 1'b0;
  logic [CW-1:0] pkt_count;
  logic [CW-1:0] drop_count;
  logic [SIZE:0] occupied;

  int          n_cmp = 0;
  int          n_err = 0;
  logic [64:0] sb[$];
  int          beats_acc = 0;
  int          stall_cnt = 0;
  bit          rand_gap = 0;
  bit          done = 0;

  zf_s2h_pkt_gate #(.SIZE(SIZE), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .i_tdata(i_tdata), .i_tlast(i_tlast), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tlast(o_tlast), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .pkt_count(pkt_count), .drop_count(drop_count), .occupied(occupied)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    rst      = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic send_beat(input logic [63:0] d, input logic last);
    bit acc;
    int t;
    if (rand_gap)
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    i_tdata  = d;
    i_tlast  = last;
    i_tvalid = 1'b1;
    acc = 0;
    t   = 0;
    while (!acc && t < 2000) begin
      @(negedge clk);
      acc = i_tready;
      if (!acc) stall_cnt++;
      @(posedge clk);
      #1;
      t++;
    end
    i_tvalid = 1'b0;
    i_tlast  = 1'b0;
    if (!acc) begin
      n_cmp++;
      n_err++;
      $display("FAIL send_timeout: beat %h never accepted", d);
    end else begin
      beats_acc++;
    end
  endtask

  task automatic send_pkt(input int len, input int id, input bit expect_out);
    logic [63:0] d;
    logic        last;
    for (int b = 0; b < len; b++) begin
      d    = (64'(id) << 32) | 64'(b);
      last = (b == len - 1);
      if (expect_out) sb.push_back({last, d});
      send_beat(d, last);
    end
  endtask

  task automatic drain();
    int t = 0;
    while ((sb.size() != 0 || o_tvalid) && t < 4000) begin
      @(negedge clk);
      t++;
    end
    check("drain_left", sb.size(), 0);
  endtask

  task automatic monitor();
    logic        prev_stall = 1'b0;
    logic [64:0] prev_d = '0;
    logic [64:0] exp;
    forever begin
      @(negedge clk);
      if (rst || clear) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          n_cmp++;
          if (!o_tvalid || {o_tlast, o_tdata} !== prev_d) begin
            n_err++;
            $display("FAIL hold_stable: got v=%0b %h expected v=1 %h", o_tvalid, {o_tlast, o_tdata}, prev_d);
          end
        end
        if (o_tvalid && o_tready) begin
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL out_extra: got %h expected no beat", {o_tlast, o_tdata});
          end else begin
            exp = sb.pop_front();
            if ({o_tlast, o_tdata} !== exp) begin
              n_err++;
              $display("FAIL out_beat: got %h expected %h", {o_tlast, o_tdata}, exp);
            end
          end
        end
        prev_stall = o_tvalid && !o_tready;
        prev_d     = {o_tlast, o_tdata};
      end
    end
  endtask

  initial begin
    fork
      monitor();
      begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
      end
      begin
        // Reset values
        @(negedge clk);
        check("rst_i_tready", i_tready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_i_tready_after", i_tready, 1);
        check("rst_o_tvalid", o_tvalid, 0);
        check("rst_o_tlast", o_tlast, 0);
        check("rst_o_tdata", o_tdata, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_drop_count", drop_count, 0);
        check("rst_occupied", occupied, 0);

        // 1: single 5-beat packet and its latency
        @(posedge clk); #1;
        o_tready = 1'b1;
        send_pkt(5, 1, 1);
        @(negedge clk);
        check("lat_edge_n", o_tvalid, 0);
        @(negedge clk);
        check("lat_edge_n1", o_tvalid, 0);
        @(negedge clk);
        check("lat_edge_n2", o_tvalid, 1);
        drain();
        check("t1_pkt_count", pkt_count, 1);

        // 2: three 4-word packets held, then released contiguously
        do_reset();
        o_tready  = 1'b0;
        stall_cnt = 0;
        for (int p = 0; p < 3; p++) send_pkt(4, 20 + p, 1);
        check("t2_stalls", stall_cnt, 0);
        @(negedge clk);
        check("t2_occupied_peak", occupied, 12);
        @(posedge clk); #1;
        o_tready = 1'b1;
        begin
          int hi = 0;
          for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (o_tvalid) hi++;
          end
          check("t2_contiguous", hi, 12);
        end
        drain();
        check("t2_pkt_count", pkt_count, 3);

        // 3: oversize packet dropped, following packet intact
        do_reset();
        o_tready = 1'b1;
        send_pkt(20, 30, 0);
        send_pkt(3, 31, 1);
        drain();
        check("t3_drop_count", drop_count, 1);
        check("t3_pkt_count", pkt_count, 1);

        // 4: backpressure when the ring fills behind committed data
        do_reset();
        o_tready = 1'b0;
        send_pkt(10, 40, 1);
        beats_acc = 0;
        fork
          send_pkt(6, 41, 1);
          begin
            repeat (20) @(negedge clk);
            check("t4_beats_before_full", beats_acc, 5);
            check("t4_i_tready_low", i_tready, 0);
            check("t4_occupied_full", occupied, 15);
            @(posedge clk); #1;
            o_tready = 1'b1;
          end
        join
        drain();
        check("t4_pkt_count", pkt_count, 2);
        check("t4_drop_count", drop_count, 0);

        // 5: random lengths, gaps and output readiness
        do_reset();
        rand_gap = 1;
        done     = 0;
        fork
          begin
            for (int p = 0; p < 200; p++) send_pkt($urandom_range(1, 15), 100 + p, 1);
            done = 1;
          end
          begin
            while (!done) begin
              @(posedge clk); #1;
              o_tready = 1'($urandom_range(0, 1));
            end
          end
        join
        rand_gap = 0;
        o_tready = 1'b1;
        drain();
        check("t5_pkt_count", pkt_count, 200);
        check("t5_drop_count", drop_count, 0);

        // 6: clear mid-packet with two packets committed
        do_reset();
        o_tready = 1'b0;
        send_pkt(3, 60, 0);
        send_pkt(3, 61, 0);
        send_beat(64'hDEAD_0000, 1'b0);
        send_beat(64'hDEAD_0001, 1'b0);
        clear = 1'b1;
        @(posedge clk); #1;
        clear = 1'b0;
        @(negedge clk);
        check("t6_o_tvalid", o_tvalid, 0);
        check("t6_occupied", occupied, 0);
        check("t6_pkt_count", pkt_count, 2);
        @(posedge clk); #1;
        o_tready = 1'b1;
        send_pkt(4, 62, 1);
        drain();
        check("t6_pkt_count_after", pkt_count, 3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
      end
    join
  end

endmodule
